// File: rtl/sol1_bus_unit_pkg.sv
// Shared definitions for the SOL-1 bus unit: bus FSM states, page-table
// entry layout and address geometry.
package sol1_bus_unit_pkg;

    // Bus sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_XLATE  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_WAITST = 3'd4,
        ST_DMA    = 3'd5,
        ST_HALT   = 3'd6
    } bus_state_t;

    // Page-table entry layout: {writable, present, ppn[10:0]}.
    localparam int PTE_W        = 13;
    localparam int PTE_PRESENT  = 11;
    localparam int PTE_WRITABLE = 12;
    localparam int PPN_W        = 11;

    // Address geometry: 2 KiB pages, 16-bit virtual, 22-bit physical.
    localparam int PAGE_OFS_W = 11;
    localparam int VADDR_W    = 16;
    localparam int PADDR_W    = 22;

    // A memory access faults when the page is absent, or when a write
    // targets a read-only page.
    function automatic logic pte_fault(input logic [PTE_W-1:0] pte,
                                       input logic             is_wr);
        return !pte[PTE_PRESENT] || (is_wr && !pte[PTE_WRITABLE]);
    endfunction

endpackage

// File: rtl/sol1_page_table.sv
// Page-table RAM: single port, synchronous write, registered read.
// Contents are deliberately not reset; the OS fills the table.
module sol1_page_table
    import sol1_bus_unit_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    idx,
    input  logic [PTE_W-1:0] wdata,
    output logic [PTE_W-1:0] rdata
);

    logic [PTE_W-1:0] mem [0:(1<<AW)-1];

    // Write on we; read data appears one cycle after the index is presented.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/sol1_bus_unit.sv
// SOL-1 bus unit: turns microcode read/write requests into external bus
// cycles, translates virtual addresses through the page table, inserts
// wait states, hands the bus to DMA and holds the halt latch.
//
// Handshake: req_rd/req_wr are levels held by the core until it sees done
// (or page_fault) high for one cycle; the unit refuses a new request in that
// cycle so a stale level is never taken as a second request. dma_req is a
// level; dma_ack stays high for as long as the bus is handed over.
module sol1_bus_unit
    import sol1_bus_unit_pkg::*;
#(
    parameter int PTB_W      = 5,
    parameter int MIN_STROBE = 1
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                req_rd,
    input  logic                req_wr,
    input  logic                req_io,
    input  logic [15:0]         mar,
    input  logic [15:0]         mdr,
    input  logic                mdr_out_src,
    input  logic [PTB_W-1:0]    ptb,
    input  logic                force_user_ptb,
    input  logic                paging_en,
    input  logic                pt_we,
    input  logic                halt_req,
    input  logic                wake,
    input  logic                dma_req,
    input  logic                pad_wait,
    input  logic [7:0]          data_bus_in,
    output logic [21:0]         addr,
    output logic [7:0]          data_out,
    output logic                rd,
    output logic                wr,
    output logic                mem_io,
    output logic                halt,
    output logic                dma_ack,
    output logic [7:0]          rd_data,
    output logic                done,
    output logic                page_fault
);

    localparam int PT_AW = PTB_W + 5;
    localparam int CNT_W = (MIN_STROBE > 1) ? $clog2(MIN_STROBE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_STROBE - 1);

    bus_state_t           state_q, state_d;
    logic                 from_halt_q, from_halt_d;
    logic                 cyc_wr_q, cyc_io_q;
    logic [CNT_W-1:0]     strobe_cnt;
    logic                 done_q, page_fault_q;

    logic                 accept, load_bus, finish, fault, cnt_inc;
    logic                 strobing;
    logic [PTB_W-1:0]     ptb_eff;
    logic [PT_AW-1:0]     pt_idx;
    logic [PTE_W-1:0]     pte;
    logic                 pt_we_idle;
    logic [PADDR_W-1:0]   xlate_addr;
    logic [7:0]           wbyte;

    // Page-table base, with the user half selected by forcing its MSB.
    always_comb begin
        ptb_eff = ptb;
        if (force_user_ptb) begin
            ptb_eff[PTB_W-1] = 1'b1;
        end
    end

    assign pt_idx     = {ptb_eff, mar[VADDR_W-1:PAGE_OFS_W]};
    // Table updates only land while the bus is idle, so an in-flight
    // translation never sees its own entry change underneath it.
    assign pt_we_idle = pt_we && (state_q == ST_IDLE);

    sol1_page_table #(
        .AW (PT_AW)
    ) u_page_table (
        .clk   (clk),
        .we    (pt_we_idle),
        .idx   (pt_idx),
        .wdata (mdr[PTE_W-1:0]),
        .rdata (pte)
    );

    // Physical address: paged memory cycles use the PPN, IO and unpaged
    // cycles pass the virtual address through zero-extended.
    always_comb begin
        if (paging_en && !cyc_io_q) begin
            xlate_addr = {pte[PPN_W-1:0], mar[PAGE_OFS_W-1:0]};
        end else begin
            xlate_addr = PADDR_W'(mar);
        end
    end

    assign wbyte = mdr_out_src ? mdr[15:8] : mdr[7:0];

    // State register and the halt-return flag for DMA taken from HALT.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            from_halt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            from_halt_q <= from_halt_d;
        end
    end

    // Next-state and per-cycle control strobes for the bus sequencer.
    always_comb begin
        state_d     = state_q;
        from_halt_d = from_halt_q;
        accept      = 1'b0;
        load_bus    = 1'b0;
        finish      = 1'b0;
        fault       = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_req) begin
                    state_d     = ST_DMA;
                    from_halt_d = 1'b0;
                end else if ((req_rd || req_wr) && !done_q && !page_fault_q) begin
                    state_d = ST_XLATE;
                    accept  = 1'b1;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_XLATE: begin
                if (paging_en && !cyc_io_q && pte_fault(pte, cyc_wr_q)) begin
                    fault   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    load_bus = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (strobe_cnt == CNT_LAST) begin
                    if (pad_wait) begin
                        state_d = ST_WAITST;
                    end else begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_WAITST: begin
                if (!pad_wait) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DMA: begin
                if (!dma_req) begin
                    state_d = from_halt_q ? ST_HALT : ST_IDLE;
                end
            end
            ST_HALT: begin
                if (dma_req) begin
                    state_d     = ST_DMA;
                    from_halt_d = 1'b1;
                end else if (wake) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Minimum strobe width counter; idles at zero outside STROBE.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            strobe_cnt <= '0;
        end else if (cnt_inc) begin
            strobe_cnt <= strobe_cnt + 1'b1;
        end else begin
            strobe_cnt <= '0;
        end
    end

    // Cycle kind latch, bus drive registers, read capture and result pulses.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cyc_wr_q     <= 1'b0;
            cyc_io_q     <= 1'b0;
            addr         <= '0;
            mem_io       <= 1'b0;
            data_out     <= '0;
            rd_data      <= '0;
            done_q       <= 1'b0;
            page_fault_q <= 1'b0;
        end else begin
            done_q       <= finish;
            page_fault_q <= fault;
            if (accept) begin
                // Both requests high is treated as a read.
                cyc_wr_q <= req_wr && !req_rd;
                cyc_io_q <= req_io;
            end
            if (load_bus) begin
                addr   <= xlate_addr;
                mem_io <= cyc_io_q;
                if (cyc_wr_q) begin
                    data_out <= wbyte;
                end
            end
            if (finish && !cyc_wr_q) begin
                rd_data <= data_bus_in;
            end
        end
    end

    // Strobes and status decode straight from state, so arst drops them
    // without waiting for a clock.
    assign strobing   = (state_q == ST_STROBE) || (state_q == ST_WAITST);
    assign rd         = strobing && !cyc_wr_q;
    assign wr         = strobing && cyc_wr_q;
    assign dma_ack    = (state_q == ST_DMA);
    assign halt       = (state_q == ST_HALT) || ((state_q == ST_DMA) && from_halt_q);
    assign done       = done_q;
    assign page_fault = page_fault_q;

endmodule

// File: doc/sol1_bus_unit.md
Name: sol1_bus_unit

Overview:
- Downstream of the CPU core. Converts the core's microcode memory/IO requests (MAR, MDR, rd/wr requests) into external 22-bit bus cycles.
- Owns the page table RAM and the virtual-to-physical translation.
- Also handles pad_wait wait states, DMA bus hand-off and the halt latch.
- Feeds the core the read data, a done pulse and a page-fault flag.

Parameters:
- PTB_W, 5: width of the page-table-base field; the table holds 2^(PTB_W+5) entries.
- MIN_STROBE, 1: minimum number of cycles rd/wr stays asserted before pad_wait is sampled.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- req_rd  in  1  microcode read request; level, held until done
- req_wr  in  1  microcode write request; level, held until done
- req_io  in  1  1 = IO space, 0 = memory space
- mar  in  16  virtual address {marh,marl}
- mdr  in  16  {mdrh,mdrl}; low byte is write data, full word is page-table write data
- mdr_out_src  in  1  selects the write byte (1 = mdr[15:8])
- ptb  in  PTB_W  kernel page-table base
- force_user_ptb  in  1  replaces the ptb MSB with 1
- paging_en  in  1  translation enable (cpu_status bit)
- pt_we  in  1  page-table write strobe, active-high, single cycle
- halt_req  in  1  microcode HALT
- wake  in  1  int_pending; clears halt
- dma_req  in  1  external DMA request
- pad_wait  in  1  external wait, active-high
- data_bus_in  in  8  external read data
- addr  out  22  physical address
- data_out  out  8  write data
- rd  out  1  read strobe
- wr  out  1  write strobe
- mem_io  out  1  1 = IO cycle
- halt  out  1  halted indicator
- dma_ack  out  1  bus granted to DMA
- rd_data  out  8  captured read byte
- done  out  1  one-cycle completion pulse
- page_fault  out  1  one-cycle fault pulse

Behaviour:
- Reset values: addr=0, data_out=0, rd=wr=mem_io=halt=dma_ack=done=page_fault=0, rd_data=0, state=IDLE. Page table contents are not reset.
- Page-table index: {ptb with MSB forced to 1 when force_user_ptb, mar[15:11]}.
- Page-table entry: 13 bits. [10:0] = physical page number, [11] = present, [12] = writable.
- pt_we writes mdr[12:0] at the current index on the rising edge. It is ignored while state != IDLE.
- Translation:
  - paging_en=1: addr = {ppn, mar[10:0]}.
  - paging_en=0: addr = {6'b0, mar}.
  - IO cycles are never translated.
- Page-table read is synchronous, 1 cycle. That cycle is the XLATE state.
- FSM states: IDLE, XLATE, SETUP, STROBE, WAITST, DMA, HALT.
- IDLE arbitration priority: dma_req > req_rd/req_wr > halt_req.
- req_rd and req_wr both high is illegal; treat it as a read.
- IDLE -> XLATE on a request; the kind (rd/wr/io) is latched.
- XLATE -> fault when paging_en and memory cycle and (!present, or write and !writable). On fault: pulse page_fault for 1 cycle, no strobe, return to IDLE.
- XLATE -> SETUP otherwise.
- SETUP: drive addr, mem_io and data_out (write). Strobes stay low. Lasts 1 cycle.
- STROBE: rd or wr high for MIN_STROBE cycles. Then:
  - pad_wait=1 -> WAITST.
  - pad_wait=0 -> complete.
- WAITST: strobe stays high until pad_wait=0 is sampled, then complete.
- Complete:
  - On a read, capture data_bus_in into rd_data on the same edge that deasserts rd.
  - Pulse done for 1 cycle and return to IDLE.
  - addr is held stable until the next request.
- Latency with no wait: request to done is 3+MIN_STROBE cycles (4 by default).
- A new request is not accepted in the cycle done is high; the core drops req on seeing done.
- DMA:
  - IDLE with dma_req -> DMA. dma_ack rises next edge; rd/wr stay 0.
  - Exit to IDLE when dma_req=0; dma_ack clears on the same edge.
  - dma_req arriving mid-cycle is deferred until IDLE.
- HALT:
  - IDLE with halt_req (no dma_req) -> HALT; halt=1.
  - wake=1 -> IDLE, halt=0.
  - While in HALT, dma_req -> DMA; halt stays 1 and the FSM returns to HALT after DMA.
- arst mid-cycle: all strobes drop immediately (async) and state returns to IDLE.

Decomposition:
- Shared package holds: the bus FSM state enum, the PTE field bit positions (PTE_PRESENT=11, PTE_WRITABLE=12), and the page size constant (11 offset bits).
- One sub-module: sol1_page_table. Synchronous single-port RAM, 2^(PTB_W+5) x 13, with write enable and a registered read.

Test Plan:
- Paging off, read mar=16'h1234, pad_wait=0, data_bus_in=8'hA5 -> addr=22'h001234, rd high 1 cycle, done 4 cycles after req, rd_data=A5.
- pt_we with ptb=3, mar[15:11]=2, mdr=16'h1805; then paging on, write mar=16'h1010, mdr[7:0]=8'h3C -> addr=22'h002810 (ppn 5), wr high, data_out=3C.
- PTE present=0, read -> page_fault pulses once, rd/wr stay 0, no done.
- PTE writable=0, write -> page_fault; same PTE, read -> completes normally.
- pad_wait high 3 cycles during STROBE -> rd high 4 cycles total, done one cycle after rd drops.
- halt_req, then dma_req -> halt=1, dma_ack=1; dma_req=0 -> dma_ack=0, halt=1; wake -> halt=0. arst during WAITST -> rd=0 and state IDLE immediately.
